// File: rtl/cpu_mem_pkg.sv
// Shared types and widths for the data-memory arbiter.
// Consumed by data_mem_arbiter and mem_arb_pick.
package cpu_mem_pkg;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 16;

    typedef enum logic {
        PORT_CPU = 1'b0,
        PORT_DBG = 1'b1
    } port_id_t;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    typedef struct packed {
        logic                  we;
        logic [ADDR_W-1:0]     addr;
        logic [DATA_W-1:0]     wdata;
        port_id_t              id;
    } mem_cmd_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational two-port grant selector producing a one-hot grant.
// pref_dbg breaks ties in favour of port 1.
module mem_arb_pick (
    input  logic [1:0] valid,
    input  logic       pref_dbg,
    output logic [1:0] grant
);

    // A lone requester wins outright; pref_dbg only matters on contention.
    always_comb begin
        grant = valid;
        if (valid == 2'b11) begin
            grant = pref_dbg ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares the single-port data memory between the CPU MEM stage (port 0) and the debug/DMA loader (port 1).
// Define ARB_RR_EN for round-robin arbitration; otherwise fixed priority with a port-1 starvation guard.
//
// state     | meaning
// ST_IDLE   | bus idle, mem_we low
// ST_ACCESS | registered command drives mem_*, response issued next cycle
module data_mem_arbiter #(
    parameter int ADDR_W       = cpu_mem_pkg::ADDR_W,
    parameter int DATA_W       = cpu_mem_pkg::DATA_W,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,
    output logic              resp0_valid,
    output logic [DATA_W-1:0] resp0_rdata,
    input  logic              req1_valid,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,
    output logic              resp1_valid,
    output logic [DATA_W-1:0] resp1_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    import cpu_mem_pkg::*;

    state_t            state_q, state_d;
    mem_cmd_t          cmd_q, cmd_d;
    logic              resp0_valid_q, resp0_valid_d;
    logic              resp1_valid_q, resp1_valid_d;
    logic [DATA_W-1:0] resp0_rdata_q, resp0_rdata_d;
    logic [DATA_W-1:0] resp1_rdata_q, resp1_rdata_d;
    logic [1:0]        grant;
    logic              pref_dbg;
    logic              accept;

`ifdef ARB_RR_EN
    logic rr_ptr_q, rr_ptr_d;

    assign pref_dbg = rr_ptr_q;

    // Preference passes to the port that did not just win.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant[1]) begin
            rr_ptr_d = 1'b0;
        end else if (grant[0]) begin
            rr_ptr_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr_q <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`else
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

    assign pref_dbg = (starve_cnt_q == CNT_W'(STARVE_LIMIT));

    always_comb begin
        starve_cnt_d = '0;
        if (req1_valid && !grant[1]) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`endif

    mem_arb_pick u_pick (
        .valid    ({req1_valid, req0_valid}),
        .pref_dbg (pref_dbg),
        .grant    (grant)
    );

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign accept     = |grant;

    always_comb begin
        state_d = accept ? ST_ACCESS : ST_IDLE;

        // Address/data hold their last value while idle; only the write enable drops.
        cmd_d    = cmd_q;
        cmd_d.we = 1'b0;
        if (grant[1]) begin
            cmd_d.we    = req1_we;
            cmd_d.addr  = req1_addr;
            cmd_d.wdata = req1_wdata;
            cmd_d.id    = PORT_DBG;
        end else if (grant[0]) begin
            cmd_d.we    = req0_we;
            cmd_d.addr  = req0_addr;
            cmd_d.wdata = req0_wdata;
            cmd_d.id    = PORT_CPU;
        end

        resp0_valid_d = (state_q == ST_ACCESS) && (cmd_q.id == PORT_CPU);
        resp1_valid_d = (state_q == ST_ACCESS) && (cmd_q.id == PORT_DBG);
        resp0_rdata_d = (resp0_valid_d && !cmd_q.we) ? mem_rdata : resp0_rdata_q;
        resp1_rdata_d = (resp1_valid_d && !cmd_q.we) ? mem_rdata : resp1_rdata_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            cmd_q         <= '0;
            resp0_valid_q <= 1'b0;
            resp1_valid_q <= 1'b0;
            resp0_rdata_q <= '0;
            resp1_rdata_q <= '0;
        end else begin
            state_q       <= state_d;
            cmd_q         <= cmd_d;
            resp0_valid_q <= resp0_valid_d;
            resp1_valid_q <= resp1_valid_d;
            resp0_rdata_q <= resp0_rdata_d;
            resp1_rdata_q <= resp1_rdata_d;
        end
    end

    assign mem_we      = cmd_q.we;
    assign mem_addr    = cmd_q.addr;
    assign mem_wdata   = cmd_q.wdata;
    assign resp0_valid = resp0_valid_q;
    assign resp1_valid = resp1_valid_q;
    assign resp0_rdata = resp0_rdata_q;
    assign resp1_rdata = resp1_rdata_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a negedge-write memory model.
// Build with ARB_RR_EN defined to exercise the round-robin variant.
module tb_data_mem_arbiter;
    import cpu_mem_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req0_we, req1_valid, req1_we;
    logic [3:0]  req0_addr, req1_addr;
    logic [15:0] req0_wdata, req1_wdata;
    logic        req0_ready, req1_ready, resp0_valid, resp1_valid;
    logic [15:0] resp0_rdata, resp1_rdata;
    logic        mem_we;
    logic [3:0]  mem_addr;
    logic [15:0] mem_wdata, mem_rdata;
    logic [15:0] mem [16];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always @(negedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;
    assign mem_rdata = mem[mem_addr];

    data_mem_arbiter dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_ready(req0_ready),
        .resp0_valid(resp0_valid), .resp0_rdata(resp0_rdata),
        .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_ready(req1_ready),
        .resp1_valid(resp1_valid), .resp1_rdata(resp1_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected port-1 grant on the k-th cycle of continuous contention.
    function automatic logic exp_g1(input int k);
`ifdef ARB_RR_EN
        return (k % 2) == 0;
`else
        return (k > 0) && ((k % 5) == 0);
`endif
    endfunction

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 16'h0;
        reset = 1'b0;
        req0_valid = 0; req0_we = 0; req0_addr = 0; req0_wdata = 0;
        req1_valid = 0; req1_we = 0; req1_addr = 0; req1_wdata = 0;
        #3;
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_resp0_valid", resp0_valid, 0);
        chk("rst_resp1_valid", resp1_valid, 0);
        chk("rst_resp0_rdata", resp0_rdata, 0);
        chk("rst_resp1_rdata", resp1_rdata, 0);
        tick();
        reset = 1'b1;

        // Idle: no valids for 10 cycles.
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("idle_ready0_%0d", i), req0_ready, 0);
            chk($sformatf("idle_ready1_%0d", i), req1_ready, 0);
            chk($sformatf("idle_mem_we_%0d", i), mem_we, 0);
            chk($sformatf("idle_resp_%0d", i), {resp1_valid, resp0_valid}, 0);
            chk($sformatf("idle_state_%0d", i), dut.state_q, ST_IDLE);
        end

        // Port 0 write then read of the same address.
        req0_valid = 1; req0_we = 1; req0_addr = 4'd3; req0_wdata = 16'hBEEF;
        #1 chk("wr_ready0", req0_ready, 1);
        tick();
        chk("wr_mem_we", mem_we, 1);
        chk("wr_mem_addr", mem_addr, 3);
        chk("wr_mem_wdata", mem_wdata, 16'hBEEF);
        req0_we = 0;
        #1 chk("rd_ready0", req0_ready, 1);
        tick();
        req0_valid = 0;
        chk("wr_resp0_valid", resp0_valid, 1);
        chk("rd_mem_we", mem_we, 0);
        tick();
        chk("rd_resp0_valid", resp0_valid, 1);
        chk("rd_resp0_rdata", resp0_rdata, 16'hBEEF);
        tick();
        chk("after_resp0_valid", resp0_valid, 0);
        chk("hold_resp0_rdata", resp0_rdata, 16'hBEEF);

        // Port 1 streams 16 writes of addr*3, then 16 reads, with no bubbles.
        for (int i = 0; i < 16; i++) begin
            req1_valid = 1; req1_we = 1; req1_addr = 4'(i); req1_wdata = 16'(i * 3);
            #1;
            chk($sformatf("stw_ready1_%0d", i), req1_ready, 1);
            chk($sformatf("stw_resp1_%0d", i), resp1_valid, (i >= 2) ? 1 : 0);
            tick();
        end
        for (int j = 0; j < 19; j++) begin
            req1_valid = (j < 16); req1_we = 0; req1_addr = 4'(j);
            #1;
            chk($sformatf("str_resp1_%0d", j), resp1_valid, (j < 18) ? 1 : 0);
            if (j >= 2 && j < 18) chk($sformatf("str_rdata1_%0d", j), resp1_rdata, (j - 2) * 3);
            tick();
        end
        req1_valid = 0;

        // Continuous contention on both ports.
        req0_valid = 1; req0_we = 0; req0_addr = 4'd1;
        req1_valid = 1; req1_we = 0; req1_addr = 4'd2;
        for (int k = 1; k <= 12; k++) begin
            #1;
            chk($sformatf("arb_ready1_%0d", k), req1_ready, exp_g1(k));
            chk($sformatf("arb_ready0_%0d", k), req0_ready, !exp_g1(k));
            if (k >= 3) begin
                chk($sformatf("arb_resp1_%0d", k), resp1_valid, exp_g1(k - 2));
                chk($sformatf("arb_resp0_%0d", k), resp0_valid, !exp_g1(k - 2));
                if (exp_g1(k - 2)) chk($sformatf("arb_rdata1_%0d", k), resp1_rdata, 16'd6);
                else chk($sformatf("arb_rdata0_%0d", k), resp0_rdata, 16'd3);
            end
            tick();
        end
        req0_valid = 0; req1_valid = 0;
        tick(); tick(); tick();

        // Reset asserted while a write is on the bus.
        req0_valid = 1; req0_we = 1; req0_addr = 4'd5; req0_wdata = 16'h1234;
        tick();
        req0_valid = 0;
        chk("mid_mem_we", mem_we, 1);
        reset = 1'b0;
        #1;
        chk("mid_rst_mem_we", mem_we, 0);
        chk("mid_rst_mem_addr", mem_addr, 0);
        chk("mid_rst_mem_wdata", mem_wdata, 0);
        chk("mid_rst_resp1_rdata", resp1_rdata, 0);
        chk("mid_rst_resp0_rdata", resp0_rdata, 0);
        tick();
        chk("mid_rst_resp0_valid", resp0_valid, 0);
        chk("mid_rst_lost_write", mem[5], 16'd15);
        reset = 1'b1;
        tick();
        chk("post_rst_state", dut.state_q, ST_IDLE);
        chk("post_rst_resp", {resp1_valid, resp0_valid}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
